// File: rtl/decap_cmp_seq_pkg.sv
// Shared types and constants for the decapsulation compare sequencer.
// The optional watchdog is enabled with the CMP_WATCHDOG_EN macro.

package decap_cmp_seq_pkg;

  // Upper bound on segments per run.
  localparam int unsigned DcsNumSegMax = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StLaunch = 3'd2,
    StWait   = 3'd3,
    StNext   = 3'd4,
    StFin    = 3'd5
  } dcs_state_e;

  // Width of the segment index: clog2(n), at least one bit.
  function automatic int unsigned dcs_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decap_cmp_seq_if.sv
// Control and engine-side signals of the compare sequencer.
// o_timeout exists only when CMP_WATCHDOG_EN is defined.

interface decap_cmp_seq_if #(
  parameter int unsigned AW      = 10,
  parameter int unsigned NUM_SEG = 2
);

  // Host side
  logic                  i_start;
  logic [NUM_SEG*AW-1:0] i_seg_start_addr;
  logic [NUM_SEG*AW-1:0] i_seg_end_addr;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_fail;
  logic                  o_sel_s;
`ifdef CMP_WATCHDOG_EN
  logic                  o_timeout;
`endif

  // mem_compare side
  logic                  o_cmp_start;
  logic [AW-1:0]         o_cmp_start_addr;
  logic [AW-1:0]         o_cmp_end_addr;
  logic                  i_cmp_done;
  logic                  i_cmp_fail;

  // The sequencer itself.
  modport slave (
    input  i_start, i_seg_start_addr, i_seg_end_addr, i_cmp_done, i_cmp_fail,
`ifdef CMP_WATCHDOG_EN
    output o_timeout,
`endif
    output o_cmp_start, o_cmp_start_addr, o_cmp_end_addr, o_busy, o_done, o_fail, o_sel_s
  );

  // Whoever drives the sequencer and plays the engine.
  modport master (
    output i_start, i_seg_start_addr, i_seg_end_addr, i_cmp_done, i_cmp_fail,
`ifdef CMP_WATCHDOG_EN
    input  o_timeout,
`endif
    input  o_cmp_start, o_cmp_start_addr, o_cmp_end_addr, o_busy, o_done, o_fail, o_sel_s
  );

endinterface

// File: rtl/decap_cmp_seq.sv
// Sequencer for mem_compare in the FrodoKEM decapsulation FO check. Walks NUM_SEG address
// segments in order, ORs the per-segment fail flags and drives the s / k' select. Every segment
// always runs, so run time is independent of the compare results.
// Optional watchdog per segment: define CMP_WATCHDOG_EN.

module decap_cmp_seq
  import decap_cmp_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = 128,
  parameter int unsigned MAX_MEM_DEPTH = 640,
  parameter int unsigned NUM_SEG       = 2,
  parameter int unsigned WD_SLACK      = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  decap_cmp_seq_if.slave bus_io
);

  localparam int unsigned AW   = $clog2(MAX_MEM_DEPTH);
  localparam int unsigned SegW = dcs_idx_w(NUM_SEG);

  // Elaboration-time parameter sanity; WIDTH is carried only for consistency with mem_compare.
  if (NUM_SEG < 1 || NUM_SEG > DcsNumSegMax) begin : g_bad_num_seg
    $error("NUM_SEG must be in 1..%0d", DcsNumSegMax);
  end
  if (WIDTH == 0 || MAX_MEM_DEPTH < 2) begin : g_bad_mem
    $error("WIDTH must be nonzero and MAX_MEM_DEPTH at least 2");
  end
  if (WD_SLACK > 32'h0000_FFFF) begin : g_bad_slack
    $error("WD_SLACK too large for the watchdog counter");
  end

  dcs_state_e      state_q, state_d;
  logic [SegW-1:0] seg_idx_q, seg_idx_d;
  logic [AW-1:0]   start_addr_q, start_addr_d;
  logic [AW-1:0]   end_addr_q, end_addr_d;
  logic            busy_q, busy_d;
  logic            fail_q, fail_d;
  logic            sel_s_q, sel_s_d;

  logic [AW-1:0]   seg_start;
  logic [AW-1:0]   seg_end;
  logic            seg_last;

`ifdef CMP_WATCHDOG_EN
  logic [31:0]     wd_cnt_q, wd_cnt_d;
  logic [31:0]     wd_limit;
  logic            timeout_q, timeout_d;

  // end >= start is guaranteed while in WAIT, so the difference never wraps.
  assign wd_limit = 32'(end_addr_q - start_addr_q) + 32'd1 + WD_SLACK;
`endif

  assign seg_start = bus_io.i_seg_start_addr[32'(seg_idx_q) * AW +: AW];
  assign seg_end   = bus_io.i_seg_end_addr[32'(seg_idx_q) * AW +: AW];
  assign seg_last  = (seg_idx_q == SegW'(NUM_SEG - 1));

  // Next-state logic: segment walk, fail accumulation and the final select.
  always_comb begin
    state_d      = state_q;
    seg_idx_d    = seg_idx_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    busy_d       = busy_q;
    fail_d       = fail_q;
    sel_s_d      = sel_s_q;
`ifdef CMP_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus_io.i_start) begin
          state_d   = StLoad;
          seg_idx_d = '0;
          busy_d    = 1'b1;
          fail_d    = 1'b0;
          sel_s_d   = 1'b0;
`ifdef CMP_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end

      StLoad: begin
        start_addr_d = seg_start;
        end_addr_d   = seg_end;
        // An inverted range can never match: count it as failed and skip the engine.
        if (seg_end < seg_start) begin
          fail_d  = 1'b1;
          state_d = StNext;
        end else begin
          state_d = StLaunch;
        end
      end

      StLaunch: begin
`ifdef CMP_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        state_d = StWait;
      end

      StWait: begin
        if (bus_io.i_cmp_done) begin
          fail_d  = fail_q | bus_io.i_cmp_fail;
          state_d = StNext;
`ifdef CMP_WATCHDOG_EN
        end else if (wd_cnt_q + 32'd1 == wd_limit) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = StNext;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
`endif
        end
      end

      StNext: begin
        if (seg_last) begin
          state_d = StFin;
          busy_d  = 1'b0;
          // Select is valid together with the done pulse.
          sel_s_d = fail_q;
        end else begin
          seg_idx_d = seg_idx_q + SegW'(1);
          state_d   = StLoad;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-run abandons the run at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      seg_idx_q    <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      busy_q       <= 1'b0;
      fail_q       <= 1'b0;
      sel_s_q      <= 1'b0;
`ifdef CMP_WATCHDOG_EN
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      seg_idx_q    <= seg_idx_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      busy_q       <= busy_d;
      fail_q       <= fail_d;
      sel_s_q      <= sel_s_d;
`ifdef CMP_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus_io.o_cmp_start      = (state_q == StLaunch);
  assign bus_io.o_cmp_start_addr = start_addr_q;
  assign bus_io.o_cmp_end_addr   = end_addr_q;
  assign bus_io.o_busy           = busy_q;
  assign bus_io.o_done           = (state_q == StFin);
  assign bus_io.o_fail           = fail_q;
  assign bus_io.o_sel_s          = sel_s_q;
`ifdef CMP_WATCHDOG_EN
  assign bus_io.o_timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_decap_cmp_seq.sv
// Bench for decap_cmp_seq: table of runs played against an inline mem_compare stub, with a
// scoreboard of expected engine launches and run results, plus a reset-abort sequence.

module tb_decap_cmp_seq;

  localparam int unsigned Aw      = 10;
  localparam int unsigned NumSeg  = 2;
  localparam int unsigned WdSlack = 16;

  logic clk;
  logic rst;

  decap_cmp_seq_if #(.AW(Aw), .NUM_SEG(NumSeg)) bus ();

  decap_cmp_seq #(
    .WIDTH        (128),
    .MAX_MEM_DEPTH(640),
    .NUM_SEG      (NumSeg),
    .WD_SLACK     (WdSlack)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One run: two segments, per-segment engine fail bit, engine latency in WAIT cycles
  // (0 = engine never answers), stimulus quirks and the expected outcome.
  typedef struct {
    logic [Aw-1:0] s0, e0, s1, e1;
    bit            f0, f1;
    int            lat;
    bit            inject;
    bit            restart;
    bit            fin_start;
    bit            exp_fail;
    bit            exp_timeout;
    int            exp_launches;
  } vec_t;

  typedef struct {
    logic [Aw-1:0] s, e;
    bit            f;
  } launch_t;

  typedef struct {
    bit fail;
    bit timeout;
    int cycles;
    int launches;
  } result_t;

  launch_t launch_q[$];
  result_t result_q[$];
  vec_t    vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [Aw-1:0] s0, e0, s1, e1, input bit f0, f1,
                              input int lat, input bit inject, restart, fin_start,
                              input bit exp_fail, exp_timeout, input int exp_launches);
    vec_t v;
    v.s0 = s0; v.e0 = e0; v.s1 = s1; v.e1 = e1;
    v.f0 = f0; v.f1 = f1; v.lat = lat;
    v.inject = inject; v.restart = restart; v.fin_start = fin_start;
    v.exp_fail = exp_fail; v.exp_timeout = exp_timeout; v.exp_launches = exp_launches;
    return v;
  endfunction

  task automatic run_case(input vec_t v);
    logic [Aw-1:0] ss[2];
    logic [Aw-1:0] ee[2];
    bit            ff[2];
    result_t       r;
    result_t       got;
    launch_t       l;
    int            cyc;
    int            nl;
    int            wait_n;
    int            w;
    bit            in_wait;
    bit            cur_f;
    bit            done_seen;

    ss[0] = v.s0; ss[1] = v.s1;
    ee[0] = v.e0; ee[1] = v.e1;
    ff[0] = v.f0; ff[1] = v.f1;

    // Expected launches and run length: 1 start cycle + segments + FIN.
    r.fail     = v.exp_fail;
    r.timeout  = v.exp_timeout;
    r.launches = v.exp_launches;
    r.cycles   = 2;
    for (int k = 0; k < 2; k++) begin
      if (ee[k] >= ss[k]) begin
        l.s = ss[k]; l.e = ee[k]; l.f = ff[k];
        launch_q.push_back(l);
        w = (v.lat == 0) ? (int'(ee[k]) - int'(ss[k]) + 1 + int'(WdSlack)) : v.lat;
        r.cycles += 3 + w;
      end else begin
        r.cycles += 2;
      end
    end
    result_q.push_back(r);

    bus.i_seg_start_addr = {v.s1, v.s0};
    bus.i_seg_end_addr   = {v.e1, v.e0};
    bus.i_start          = 1'b1;
    cyc       = 1;
    nl        = 0;
    wait_n    = 0;
    in_wait   = 1'b0;
    cur_f     = 1'b0;
    done_seen = 1'b0;

    for (int t = 0; t < 2000 && !done_seen; t++) begin
      @(negedge clk);
      cyc++;
      bus.i_start    = 1'b0;
      bus.i_cmp_done = 1'b0;
      bus.i_cmp_fail = 1'b0;
      if (bus.o_cmp_start) begin
        nl++;
        if (launch_q.size() == 0) begin
          chk("launch_expected", 32'(launch_q.size()), 32'd1);
        end else begin
          l = launch_q.pop_front();
          chk("launch_start_addr", 32'(bus.o_cmp_start_addr), 32'(l.s));
          chk("launch_end_addr", 32'(bus.o_cmp_end_addr), 32'(l.e));
          cur_f = l.f;
        end
        in_wait = 1'b1;
        wait_n  = 0;
        // Done with fail in the LAUNCH cycle must not be taken.
        if (v.inject) begin
          bus.i_cmp_done = 1'b1;
          bus.i_cmp_fail = 1'b1;
        end
      end else if (in_wait) begin
        wait_n++;
        if (v.restart && wait_n == 1) bus.i_start = 1'b1;
        if (v.lat != 0 && wait_n == v.lat) begin
          bus.i_cmp_done = 1'b1;
          bus.i_cmp_fail = cur_f;
          in_wait        = 1'b0;
        end
      end
      chk("busy_during_run", 32'(bus.o_busy), 32'(!bus.o_done));
      if (bus.o_done) begin
        done_seen = 1'b1;
        got = result_q.pop_front();
        chk("run_fail", 32'(bus.o_fail), 32'(got.fail));
        chk("run_sel_s", 32'(bus.o_sel_s), 32'(got.fail));
        chk("run_cycles", 32'(cyc), 32'(got.cycles));
        chk("run_launches", 32'(nl), 32'(got.launches));
`ifdef CMP_WATCHDOG_EN
        chk("run_timeout", 32'(bus.o_timeout), 32'(got.timeout));
`endif
        if (v.fin_start) bus.i_start = 1'b1;
      end
    end

    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_within_budget: no o_done after %0d cycles", cyc);
      result_q.delete();
    end
    chk("launch_queue_drained", 32'(launch_q.size()), 32'd0);
    launch_q.delete();

    // Cycle after FIN: idle, results held, a start seen in FIN not taken.
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("post_done_low", 32'(bus.o_done), 32'd0);
    chk("post_busy_low", 32'(bus.o_busy), 32'd0);
    chk("post_fail_held", 32'(bus.o_fail), 32'(v.exp_fail));
    chk("post_sel_s_held", 32'(bus.o_sel_s), 32'(v.exp_fail));
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_cmp_start"}, 32'(bus.o_cmp_start), 32'd0);
    chk({tag, "_start_addr"}, 32'(bus.o_cmp_start_addr), 32'd0);
    chk({tag, "_end_addr"}, 32'(bus.o_cmp_end_addr), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_fail"}, 32'(bus.o_fail), 32'd0);
    chk({tag, "_sel_s"}, 32'(bus.o_sel_s), 32'd0);
`ifdef CMP_WATCHDOG_EN
    chk({tag, "_timeout"}, 32'(bus.o_timeout), 32'd0);
`endif
  endtask

  // Segment 0 fails, then reset lands in the third WAIT cycle of segment 1.
  task automatic run_reset_abort();
    int nl     = 0;
    int cd     = 0;
    int wait_n = 0;
    int stray  = 0;
    bit hit    = 1'b0;

    bus.i_seg_start_addr = {10'd40, 10'd20};
    bus.i_seg_end_addr   = {10'd50, 10'd30};
    bus.i_start          = 1'b1;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      bus.i_start    = 1'b0;
      bus.i_cmp_done = 1'b0;
      bus.i_cmp_fail = 1'b0;
      if (bus.o_cmp_start) begin
        nl++;
        cd     = (nl == 1) ? 2 : 0;
        wait_n = 0;
      end else if (nl == 1 && cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.i_cmp_done = 1'b1;
          bus.i_cmp_fail = 1'b1;
        end
      end else if (nl == 2) begin
        wait_n++;
        if (wait_n == 3) begin
          chk("abort_fail_before_reset", 32'(bus.o_fail), 32'd1);
          chk("abort_seg1_start_addr", 32'(bus.o_cmp_start_addr), 32'd40);
          rst = 1'b1;
          hit = 1'b1;
        end
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL abort_reach_seg1_wait: segment 1 WAIT not reached");
    end
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("abort");
    // Stay quiet afterwards, even with a stray done outside WAIT.
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus.i_cmp_done = (t == 4);
      bus.i_cmp_fail = (t == 4);
      if (bus.o_cmp_start || bus.o_done || bus.o_busy) stray++;
    end
    bus.i_cmp_done = 1'b0;
    bus.i_cmp_fail = 1'b0;
    chk("abort_quiet_cycles", 32'(stray), 32'd0);
    chk("abort_stray_done_ignored", 32'(bus.o_fail), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst                  = 1'b1;
    bus.i_start          = 1'b0;
    bus.i_seg_start_addr = '0;
    bus.i_seg_end_addr   = '0;
    bus.i_cmp_done       = 1'b0;
    bus.i_cmp_fail       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    //                s0        e0        s1        e1      f0 f1 lat inj rst fin  fail to  nl
    vecs.push_back(mk(10'd0,   10'd639, 10'd0,   10'd639, 0, 0, 5,  0,  0,  0,   0,   0, 2));
    vecs.push_back(mk(10'd0,   10'd639, 10'd0,   10'd639, 1, 0, 5,  0,  0,  0,   1,   0, 2));
    vecs.push_back(mk(10'd0,   10'd639, 10'd10,  10'd5,   0, 0, 5,  0,  0,  0,   1,   0, 1));
    vecs.push_back(mk(10'd0,   10'd639, 10'd0,   10'd639, 0, 0, 3,  1,  1,  0,   0,   0, 2));
    vecs.push_back(mk(10'd100, 10'd200, 10'd300, 10'd300, 0, 1, 1,  0,  0,  0,   1,   0, 2));
    vecs.push_back(mk(10'd5,   10'd4,   10'd0,   10'd0,   0, 0, 2,  0,  0,  0,   1,   0, 1));
    vecs.push_back(mk(10'd639, 10'd0,   10'd639, 10'd0,   0, 0, 2,  0,  0,  0,   1,   0, 0));
    vecs.push_back(mk(10'd639, 10'd639, 10'd0,   10'd639, 0, 0, 1,  0,  0,  1,   0,   0, 2));
`ifdef CMP_WATCHDOG_EN
    vecs.push_back(mk(10'd0,   10'd99,  10'd0,   10'd99,  0, 0, 0,  0,  0,  0,   1,   1, 2));
`endif

    foreach (vecs[i]) run_case(vecs[i]);

    run_reset_abort();
    // Fresh run after the abort starts again at segment 0.
    run_case(vecs[4]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decap_cmp_seq.md
Name: decap_cmp_seq

Overview:
- Sequencer for the mem_compare engine in the FrodoKEM decapsulation FO-transform check.
- Runs the engine over NUM_SEG address segments in order, e.g. B' vs B'' then C vs C'. ORs the per-segment fail flags together.
- Drives the final select between s (reject) and k' (accept) for shared-secret hashing.
- Always runs every segment, so run time does not depend on secret data (constant time).

Parameters:
- WIDTH, 128, word width of the compared memories (pass-through only, for consistency with mem_compare).
- MAX_MEM_DEPTH, 640, memory depth; AW = CLOG2(MAX_MEM_DEPTH).
- NUM_SEG, 2, number of segments compared per run (1..4).
- WD_SLACK, 16, extra cycles allowed beyond the segment length before the watchdog fires (CMP_WATCHDOG_EN only).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  single-cycle start pulse; sampled only in IDLE.
- i_seg_start_addr  in  NUM_SEG*AW  segment start addresses; segment k is bits [k*AW +: AW].
- i_seg_end_addr  in  NUM_SEG*AW  inclusive segment end addresses, same packing.
- o_cmp_start  out  1  single-cycle start pulse to mem_compare.
- o_cmp_start_addr  out  AW  start address for mem_compare, registered.
- o_cmp_end_addr  out  AW  end address for mem_compare, registered.
- i_cmp_done  in  1  done pulse from mem_compare.
- i_cmp_fail  in  1  fail flag from mem_compare; valid in the cycle i_cmp_done is high.
- o_busy  out  1  high from the cycle after start is accepted until o_done.
- o_done  out  1  single-cycle completion pulse.
- o_fail  out  1  sticky OR of all segment fails; held until the next accepted start.
- o_sel_s  out  1  equals o_fail after completion: 1 = hash s, 0 = hash k'.
- o_timeout  out  1  watchdog fired (present only with CMP_WATCHDOG_EN).

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge) gives:
  - state = IDLE, seg_idx = 0;
  - o_cmp_start, o_busy, o_done, o_fail, o_sel_s, o_timeout = 0;
  - address outputs = 0.
- Reset mid-run aborts at once. No o_done is produced, and no o_cmp_start appears after the reset edge.
- FSM states are IDLE, LOAD, LAUNCH, WAIT, NEXT, FIN.
- IDLE:
  - On i_start: clear o_fail, o_sel_s, o_timeout; set seg_idx = 0; set o_busy; go to LOAD.
  - i_start in any other state is ignored.
- LOAD:
  - Register segment seg_idx onto o_cmp_start_addr and o_cmp_end_addr.
  - If end < start, the segment is invalid: set fail and go to NEXT without launching the engine.
  - Otherwise go to LAUNCH.
- LAUNCH: o_cmp_start = 1 for exactly one cycle; addresses are stable from LOAD onward; go to WAIT.
- WAIT:
  - Hold the addresses stable.
  - On i_cmp_done: fail |= i_cmp_fail; go to NEXT.
  - i_cmp_done seen outside WAIT is ignored.
  - A done pulse in the same cycle as the LAUNCH pulse is not accepted.
- NEXT: if seg_idx == NUM_SEG-1, go to FIN; else seg_idx++ and go to LOAD.
- FIN:
  - o_done = 1 for one cycle; o_busy = 0; o_sel_s = o_fail; go to IDLE.
  - An i_start in the FIN cycle is ignored; one in the following IDLE cycle is accepted.
- There is no early abort on fail. All NUM_SEG segments always run (constant time).
- Latency:
  - 1 cycle (IDLE→LOAD) + per valid segment 3 cycles (LOAD, LAUNCH, NEXT) plus the mem_compare run time + FIN.
  - An invalid segment costs 2 cycles (LOAD, NEXT).
- seg_idx width is CLOG2(NUM_SEG), minimum 1.
- Address comparison is unsigned.

Optional Feature:
- Macro: CMP_WATCHDOG_EN.
- With the macro defined:
  - A counter clears in LAUNCH and increments in WAIT.
  - If it reaches (end-start+1)+WD_SLACK without i_cmp_done, the segment is treated as failed: fail = 1, o_timeout = 1 (sticky), go to NEXT.
  - A late i_cmp_done arriving afterwards is ignored.
- Without the macro: no counter, the o_timeout port is absent, and WAIT waits indefinitely.

Decomposition:
- Shared package/include (common/param.v):
  - CLOG2 macro;
  - state encodings DCS_IDLE..DCS_FIN;
  - DCS_NUM_SEG_MAX = 4.
- No sub-module is required. The watchdog counter is optionally a small sub-module, cmp_watchdog.

Test Plan:
- Segments {0..639, 0..639}, both passes match → one o_cmp_start per segment with addresses 0/639; o_done once; o_fail = 0; o_sel_s = 0.
- Segment 0 mismatches, segment 1 matches → o_cmp_start still issued twice; o_fail = 1; o_sel_s = 1; total cycles identical to the all-match run.
- Segment 1 set to start = 10, end = 5 → only one o_cmp_start; o_fail = 1; done 2 cycles after segment 0's NEXT.
- i_start pulsed again while in WAIT, and i_cmp_done injected in the LAUNCH cycle → both ignored; sequence unchanged.
- i_rst asserted in WAIT of segment 1 → next cycle all outputs 0 and state IDLE; a fresh start then runs from segment 0.
- With CMP_WATCHDOG_EN, stub that never returns done on a 0..99 segment → timeout at 116 WAIT cycles; o_timeout = 1; o_fail = 1; o_done follows.
